// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory stage of the in-order pipeline, sitting directly after execute.
//   Owns the EX/MEM and MEM/WB pipeline registers. Word loads and stores go
//   out over a req/gnt/rvalid data-memory port. The stage stalls upstream
//   while an access is outstanding and aborts an access that waits too long.
//
// Parameters
//   TIMEOUT_CYCLES : wait-state cycles before an access is aborted as a bus
//                    error (0 = never time out)
//
// Optional feature macro
//   MEM_MISALIGN_CHECK_EN : when defined, an access with addr[1:0] != 0 issues
//                           no request, completes at once without a writeback
//                           and pulses mem_misaligned_o. When undefined, the
//                           low address bits are ignored and mem_misaligned_o
//                           is tied low.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ex_*                     instruction fields from execute (into EX/MEM)
//   dmem_req_o/we_o/addr_o/wdata_o   data-memory request side
//   dmem_gnt_i/rvalid_i/rdata_i      data-memory response side
//   mem_stall_o              freeze PC/IF/ID/EX this cycle
//   ex_mem_forward_data_o    EX/MEM ALU result for forwarding
//   mem_wb_forward_data_o    MEM/WB writeback value for forwarding
//   mem_wb_rd_addr_o, mem_wb_reg_write_en_o, mem_wb_wdata_o   writeback
//   mem_bus_err_o            one-cycle pulse after a timeout abort
//   mem_misaligned_o         one-cycle pulse after a misaligned access
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write_en,
  input  logic        ex_mem_read_en,
  input  logic        ex_mem_write_en,
  input  logic [1:0]  ex_mem_to_reg,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic [31:0] ex_mem_forward_data_o,
  output logic [31:0] mem_wb_forward_data_o,
  output logic [4:0]  mem_wb_rd_addr_o,
  output logic        mem_wb_reg_write_en_o,
  output logic [31:0] mem_wb_wdata_o,
  output logic        mem_bus_err_o,
  output logic        mem_misaligned_o
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));
  localparam bit TO_ENABLED = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RD  = 2'd2
  } state_t;

  // EX/MEM register
  logic [31:0] r_alu_result;
  logic [31:0] r_rs2_data;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write_en;
  logic        r_mem_read_en;
  logic        r_mem_write_en;
  logic [1:0]  r_mem_to_reg;

  // access control
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // MEM/WB register and status pulses
  logic [4:0]  r_wb_rd_addr;
  logic        r_wb_reg_write_en;
  logic [31:0] r_wb_wdata;
  logic        r_bus_err;

  logic        w_op;
  logic        w_is_write;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_req;
  logic        w_complete;
  logic        w_abort;
  logic        w_stall;
  state_t      w_next_state;
  logic [31:0] w_wb_wdata;

  assign w_op       = r_mem_read_en | r_mem_write_en;
  // read_en & write_en together behaves as a store
  assign w_is_write = r_mem_write_en;
  assign w_timeout  = TO_ENABLED && (r_cnt == TO_LAST);

  // Misaligned detection (only meaningful with the check enabled)
  always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
    w_misaligned = w_op & (r_alu_result[1:0] != 2'b00);
`else
    w_misaligned = 1'b0;
`endif
  end

  // Access FSM next-state, request and completion decode
  always_comb begin
    w_req        = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_op && !w_misaligned) begin
          w_req = 1'b1;
          if (dmem_gnt_i) begin
            if (w_is_write) begin
              w_complete = 1'b1;
            end else begin
              w_next_state = S_WAIT_RD;
            end
          end else begin
            w_next_state = S_WAIT_GNT;
          end
        end else if (w_misaligned) begin
          // rejected locally: no bus traffic, no stall
          w_complete = 1'b1;
        end else begin
          w_complete = 1'b0;
        end
      end
      S_WAIT_GNT: begin
        w_req = 1'b1;
        // a grant arriving on the timeout cycle still wins
        if (dmem_gnt_i) begin
          if (w_is_write) begin
            w_complete   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_WAIT_RD;
          end
        end else if (w_timeout) begin
          w_complete   = 1'b1;
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT_GNT;
        end
      end
      S_WAIT_RD: begin
        if (dmem_rvalid_i) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_timeout) begin
          w_complete   = 1'b1;
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT_RD;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_stall = w_op & ~w_complete;

  // Writeback value select: only 01 picks load data
  always_comb begin
    if (r_mem_to_reg == 2'b01) begin
      w_wb_wdata = dmem_rdata_i;
    end else begin
      w_wb_wdata = r_alu_result;
    end
  end

  // EX/MEM register: advances whenever the stage is not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_result   <= 32'h0000_0000;
      r_rs2_data     <= 32'h0000_0000;
      r_rd_addr      <= 5'd0;
      r_reg_write_en <= 1'b0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_mem_to_reg   <= 2'b00;
    end else if (!w_stall) begin
      r_alu_result   <= ex_alu_result;
      r_rs2_data     <= ex_rs2_data;
      r_rd_addr      <= ex_rd_addr;
      r_reg_write_en <= ex_reg_write_en;
      r_mem_read_en  <= ex_mem_read_en;
      r_mem_write_en <= ex_mem_write_en;
      r_mem_to_reg   <= ex_mem_to_reg;
    end
  end

  // FSM state and wait-cycle counter (cleared on entering a wait state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((w_next_state != r_state) && (w_next_state != S_IDLE)) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // MEM/WB register: a stalled cycle inserts a bubble, aborts never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_rd_addr      <= 5'd0;
      r_wb_reg_write_en <= 1'b0;
      r_wb_wdata        <= 32'h0000_0000;
      r_bus_err         <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (!w_stall) begin
        r_wb_rd_addr      <= r_rd_addr;
        r_wb_reg_write_en <= r_reg_write_en & ~w_abort & ~w_misaligned;
        r_wb_wdata        <= w_wb_wdata;
      end else begin
        r_wb_reg_write_en <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misaligned;

  // Misaligned pulse, one cycle after the rejected access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misaligned;
    end
  end

  assign mem_misaligned_o = r_misaligned;
`else
  assign mem_misaligned_o = 1'b0;
`endif

  // Request side comes straight from EX/MEM, so it is stable while waiting
  assign dmem_req_o   = w_req;
  assign dmem_we_o    = w_is_write;
  assign dmem_addr_o  = {r_alu_result[31:2], 2'b00};
  assign dmem_wdata_o = r_rs2_data;

  assign mem_stall_o           = w_stall;
  assign ex_mem_forward_data_o = r_alu_result;
  assign mem_wb_forward_data_o = r_wb_wdata;
  assign mem_wb_rd_addr_o      = r_wb_rd_addr;
  assign mem_wb_reg_write_en_o = r_wb_reg_write_en;
  assign mem_wb_wdata_o        = r_wb_wdata;
  assign mem_bus_err_o         = r_bus_err;

endmodule
